// File: rtl/slice_scanner_2d_if.sv
// Frame/config input channel and row-beat output channel of slice_scanner_2d.
// The slave modport is the scanner side; master is the producer/consumer side.
interface slice_scanner_2d_if #(
    parameter int ROWS = 4,
    parameter int COLS = 8
);
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;

    logic                       in_valid;
    logic                       in_ready;
    logic [ROWS-1:0][COLS-1:0]  in_data;
    logic [RW-1:0]              cfg_row_lo;
    logic [RW-1:0]              cfg_row_hi;
    logic [CW-1:0]              cfg_col_lo;
    logic [CW-1:0]              cfg_col_hi;
    logic                       out_valid;
    logic                       out_ready;
    logic [COLS-1:0]            out_data;
    logic [RW-1:0]              out_row;
    logic                       out_last;
    logic                       busy;
    logic                       cfg_err;

    modport slave (
        input  in_valid, in_data, cfg_row_lo, cfg_row_hi, cfg_col_lo, cfg_col_hi, out_ready,
        output in_ready, out_valid, out_data, out_row, out_last, busy, cfg_err
    );

    modport master (
        output in_valid, in_data, cfg_row_lo, cfg_row_hi, cfg_col_lo, cfg_col_hi, out_ready,
        input  in_ready, out_valid, out_data, out_row, out_last, busy, cfg_err
    );
endinterface

// File: rtl/slice_scanner_2d.sv
// Captures a 2D frame plus window bounds, then streams the window one row per
// beat (ascending rows, right-aligned columns) on a backpressured output.
module slice_scanner_2d #(
    parameter int ROWS = 4,
    parameter int COLS = 8
) (
    input  logic                clk,
    input  logic                nrst,
    slice_scanner_2d_if.slave   bus
);
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
    localparam logic [RW:0] ROW_LIM = (RW+1)'(ROWS);
    localparam logic [CW:0] COL_LIM = (CW+1)'(COLS);

    typedef enum logic {IDLE, STREAM} state_t;

    state_t                     state_q, state_d;
    logic [ROWS-1:0][COLS-1:0]  frame_q, frame_d;
    logic [RW-1:0]              row_q, row_d;
    logic [RW-1:0]              row_hi_q, row_hi_d;
    logic [CW-1:0]              col_lo_q, col_lo_d;
    logic [CW-1:0]              col_hi_q, col_hi_d;
    logic                       cfg_err_q, cfg_err_d;

    logic                       accept;
    logic                       cfg_ok;
    logic                       at_last;
    logic [CW:0]                win_w;
    logic [COLS-1:0]            row_bits;
    logic [COLS-1:0]            mask;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q   <= IDLE;
            frame_q   <= '0;
            row_q     <= '0;
            row_hi_q  <= '0;
            col_lo_q  <= '0;
            col_hi_q  <= '0;
            cfg_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            frame_q   <= frame_d;
            row_q     <= row_d;
            row_hi_q  <= row_hi_d;
            col_lo_q  <= col_lo_d;
            col_hi_q  <= col_hi_d;
            cfg_err_q <= cfg_err_d;
        end
    end

    assign accept  = bus.in_valid && (state_q == IDLE);
    assign at_last = (row_q == row_hi_q);
    assign cfg_ok  = (bus.cfg_row_lo <= bus.cfg_row_hi) && ({1'b0, bus.cfg_row_hi} < ROW_LIM)
                  && (bus.cfg_col_lo <= bus.cfg_col_hi) && ({1'b0, bus.cfg_col_hi} < COL_LIM);

    always_comb begin
        state_d   = state_q;
        frame_d   = frame_q;
        row_d     = row_q;
        row_hi_d  = row_hi_q;
        col_lo_d  = col_lo_q;
        col_hi_d  = col_hi_q;
        cfg_err_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    frame_d  = bus.in_data;
                    row_hi_d = bus.cfg_row_hi;
                    col_lo_d = bus.cfg_col_lo;
                    col_hi_d = bus.cfg_col_hi;
                    if (cfg_ok) begin
                        state_d = STREAM;
                        row_d   = bus.cfg_row_lo;
                    end else begin
                        cfg_err_d = 1'b1;
                    end
                end
            end
            STREAM: begin
                if (bus.out_ready) begin
                    if (at_last) state_d = IDLE;
                    else         row_d   = row_q + RW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Mask built bitwise from the window width so a full-width window never
    // needs a 1<<COLS term that would overflow the row width.
    always_comb begin
        win_w    = {1'b0, col_hi_q} - {1'b0, col_lo_q} + (CW+1)'(1);
        row_bits = frame_q[row_q];
        for (int unsigned i = 0; i < COLS; i++) begin
            mask[i] = (i < 32'(win_w));
        end
    end

    always_comb begin
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        bus.busy      = 1'b0;
        bus.out_data  = '0;
        bus.out_row   = '0;
        bus.out_last  = 1'b0;
        bus.cfg_err   = cfg_err_q;
        case (state_q)
            IDLE: begin
                bus.in_ready = 1'b1;
            end
            STREAM: begin
                bus.out_valid = 1'b1;
                bus.busy      = 1'b1;
                bus.out_data  = (row_bits >> col_lo_q) & mask;
                bus.out_row   = row_q;
                bus.out_last  = at_last;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_slice_scanner_2d.sv
// Scoreboard bench for slice_scanner_2d: stimulus pushes expected beats from a
// bit-by-bit window model; a negedge monitor compares every presented beat.
module tb_slice_scanner_2d;
    localparam int ROWS = 4;
    localparam int COLS = 8;

    typedef struct {
        logic [7:0] data;
        logic [1:0] row;
        logic       last;
    } beat_t;

    logic clk;
    logic nrst;
    int unsigned n_cmp;
    int unsigned n_bad;
    int          rdy_force;
    beat_t       exp_q[$];

    logic       prev_stall;
    logic [7:0] prev_data;
    logic [1:0] prev_row;
    logic       prev_last;

    slice_scanner_2d_if #(.ROWS(ROWS), .COLS(COLS)) bus ();

    slice_scanner_2d #(.ROWS(ROWS), .COLS(COLS)) dut (
        .clk  (clk),
        .nrst (nrst),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference window extraction: copy bits col_lo..col_hi of row r one at a time.
    function automatic logic [7:0] ref_slice(input logic [31:0] f, input int r, input int clo, input int chi);
        logic [7:0] v;
        v = '0;
        for (int c = clo; c <= chi; c++) v[c - clo] = f[r * COLS + c];
        return v;
    endfunction

    task automatic send(input logic [31:0] f, input int rlo, input int rhi, input int clo, input int chi);
        bit ok;
        int w;
        beat_t b;
        ok = (rlo <= rhi) && (rhi < ROWS) && (clo <= chi) && (chi < COLS);
        @(negedge clk);
        bus.in_valid   = 1'b1;
        bus.in_data    = f;
        bus.cfg_row_lo = 2'(rlo);
        bus.cfg_row_hi = 2'(rhi);
        bus.cfg_col_lo = 3'(clo);
        bus.cfg_col_hi = 3'(chi);
        w = 0;
        while (!bus.in_ready && w < 200) begin
            @(negedge clk);
            w++;
        end
        if (!bus.in_ready) begin
            n_cmp++;
            n_bad++;
            $display("FAIL accept_timeout: in_ready stayed 0 for %0d cycles", w);
            bus.in_valid = 1'b0;
            return;
        end
        if (ok) begin
            for (int r = rlo; r <= rhi; r++) begin
                b.data = ref_slice(f, r, clo, chi);
                b.row  = 2'(r);
                b.last = (r == rhi);
                exp_q.push_back(b);
            end
        end
        @(posedge clk);
        #1;
        bus.in_valid   = 1'b0;
        bus.in_data    = $urandom;
        bus.cfg_row_lo = 2'($urandom);
        bus.cfg_row_hi = 2'($urandom);
        bus.cfg_col_lo = 3'($urandom);
        bus.cfg_col_hi = 3'($urandom);
        @(negedge clk);
        if (ok) begin
            check("first_beat_latency", 32'(bus.out_valid), 32'd1);
        end else begin
            check("cfg_err_pulse", 32'(bus.cfg_err), 32'd1);
            check("cfg_err_no_valid", 32'(bus.out_valid), 32'd0);
            @(negedge clk);
            check("cfg_err_cleared", 32'(bus.cfg_err), 32'd0);
            check("cfg_err_in_ready", 32'(bus.in_ready), 32'd1);
        end
    endtask

    // Called right after send() returns with out_ready forced high.
    task automatic frame_timing(input int rows);
        int nb;
        int w;
        nb = 0;
        w = 0;
        while (!bus.in_ready && w < 50) begin
            if (bus.busy) nb++;
            @(negedge clk);
            w++;
        end
        check("busy_cycles", 32'(nb), 32'(rows));
        check("in_ready_after_frame", 32'(bus.in_ready), 32'd1);
    endtask

    initial begin
        rdy_force = 1;
        bus.out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_force)
                0:       bus.out_ready = ($urandom % 4) != 0;
                1:       bus.out_ready = 1'b1;
                default: bus.out_ready = 1'b0;
            endcase
        end
    end

    always @(negedge clk) begin
        if (nrst) begin
            if (prev_stall) begin
                check("hold_valid", 32'(bus.out_valid), 32'd1);
                check("hold_data", 32'(bus.out_data), 32'(prev_data));
                check("hold_row", 32'(bus.out_row), 32'(prev_row));
                check("hold_last", 32'(bus.out_last), 32'(prev_last));
            end
            if (bus.out_valid) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_beat: data 0x%0h row %0d with empty scoreboard", bus.out_data, bus.out_row);
                end else begin
                    check("beat_data", 32'(bus.out_data), 32'(exp_q[0].data));
                    check("beat_row", 32'(bus.out_row), 32'(exp_q[0].row));
                    check("beat_last", 32'(bus.out_last), 32'(exp_q[0].last));
                    if (bus.out_ready) void'(exp_q.pop_front());
                end
            end
            check("busy_tracks_valid", 32'(bus.busy), 32'(bus.out_valid));
            check("in_ready_idle", 32'(bus.in_ready), 32'(!bus.out_valid));
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_data  = bus.out_data;
            prev_row   = bus.out_row;
            prev_last  = bus.out_last;
        end else begin
            prev_stall = 1'b0;
        end
    end

    initial begin
        int w;
        logic [31:0] f;
        int a, b, c, d, t;
        n_cmp = 0;
        n_bad = 0;
        prev_stall = 1'b0;
        nrst = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data = '0;
        bus.cfg_row_lo = '0;
        bus.cfg_row_hi = '0;
        bus.cfg_col_lo = '0;
        bus.cfg_col_hi = '0;
        #23;
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_cfg_err", 32'(bus.cfg_err), 32'd0);
        check("rst_out_data", 32'(bus.out_data), 32'd0);
        check("rst_out_row", 32'(bus.out_row), 32'd0);
        check("rst_out_last", 32'(bus.out_last), 32'd0);
        @(posedge clk);
        #1;
        nrst = 1'b1;
        @(negedge clk);
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);

        // Directed windows on 0xDEADBEEF at full rate.
        rdy_force = 1;
        send(32'hDEADBEEF, 1, 2, 2, 5);
        frame_timing(2);
        send(32'hDEADBEEF, 0, 3, 0, 7);
        frame_timing(4);
        send(32'hDEADBEEF, 3, 3, 7, 7);
        frame_timing(1);
        send(32'hDEADBEEF, 0, 0, 4, 4);
        frame_timing(1);

        // Stall the first beat, while the next frame is already offered.
        rdy_force = 2;
        send(32'hDEADBEEF, 1, 2, 2, 5);
        fork
            begin
                repeat (3) @(negedge clk);
                rdy_force = 1;
            end
            send(32'h12345678, 0, 1, 1, 6);
        join

        // Invalid configurations.
        send(32'hDEADBEEF, 2, 1, 0, 7);
        send(32'hDEADBEEF, 0, 3, 6, 3);

        // Reset while the second beat is on the output.
        rdy_force = 1;
        w = 0;
        while (!bus.in_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        send(32'hDEADBEEF, 0, 3, 0, 7);
        @(posedge clk);
        #1;
        nrst = 1'b0;
        #1;
        check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
        check("midrst_busy", 32'(bus.busy), 32'd0);
        check("midrst_out_data", 32'(bus.out_data), 32'd0);
        check("midrst_out_last", 32'(bus.out_last), 32'd0);
        exp_q.delete();
        @(negedge clk);
        @(posedge clk);
        #1;
        nrst = 1'b1;
        @(negedge clk);
        check("postrst_in_ready", 32'(bus.in_ready), 32'd1);
        send(32'hDEADBEEF, 2, 3, 1, 6);
        frame_timing(2);

        // Randomized frames with random backpressure.
        rdy_force = 0;
        for (int n = 0; n < 60; n++) begin
            f = $urandom;
            a = $urandom % ROWS;
            b = $urandom % ROWS;
            c = $urandom % COLS;
            d = $urandom % COLS;
            if (($urandom % 4) != 0) begin
                if (a > b) begin t = a; a = b; b = t; end
                if (c > d) begin t = c; c = d; d = t; end
            end
            send(f, a, b, c, d);
        end

        w = 0;
        while (exp_q.size() != 0 && w < 500) begin
            @(negedge clk);
            w++;
        end
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
